// File: rtl/wb_regfile.sv
// Architectural register file with WB write port, two ID read ports, commit trace and retire counter.
// Optional feature: define WB_BYPASS_EN for same-cycle write-through on the read ports.
module wb_regfile #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stop_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_wr_i,
  input  logic [DATA_W-1:0] wb_wd_i,
  input  logic [31:0]       wb_pc4_i,
  input  logic              wb_have_inst_i,
  input  logic [ADDR_W-1:0] ra1_i,
  input  logic [ADDR_W-1:0] ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  output logic [31:0]       dbg_pc_o,
  output logic [3:0]        dbg_we_o,
  output logic [ADDR_W-1:0] dbg_wnum_o,
  output logic [DATA_W-1:0] dbg_wdata_o,
  output logic              dbg_valid_o,
  output logic [31:0]       retired_cnt_o
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  logic              wr_en_s;
  logic              commit_s;

  logic [31:0]       dbg_pc_q,    dbg_pc_d;
  logic [3:0]        dbg_we_q,    dbg_we_d;
  logic [ADDR_W-1:0] dbg_wnum_q,  dbg_wnum_d;
  logic [DATA_W-1:0] dbg_wdata_q, dbg_wdata_d;
  logic              dbg_valid_q, dbg_valid_d;
  logic [31:0]       retired_cnt_q, retired_cnt_d;

  assign wr_en_s  = wb_we_i && (wb_wr_i != '0);
  // Stalled insts are seen repeatedly; only the cycle stop_i drops counts as the commit.
  assign commit_s = wb_have_inst_i && !stop_i && !wb_pc4_i[31];

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] val;
    if (ra == '0) begin
      val = '0;
`ifdef WB_BYPASS_EN
    end else if (wr_en_s && (ra == wb_wr_i)) begin
      val = wb_wd_i;
`endif
    end else begin
      val = rf_q[ra];
    end
    return val;
  endfunction

  // Combinational read ports
  always_comb begin
    rd1_o = read_port(ra1_i);
    rd2_o = read_port(ra2_i);
  end

  // Register-array next state; writes are not gated by stop_i (rewrite is idempotent)
  always_comb begin
    rf_d = rf_q;
    if (wr_en_s) begin
      rf_d[wb_wr_i] = wb_wd_i;
    end else begin
      rf_d = rf_q;
    end
  end

  // Trace and retire-counter next state
  always_comb begin
    dbg_pc_d      = dbg_pc_q;
    dbg_we_d      = dbg_we_q;
    dbg_wnum_d    = dbg_wnum_q;
    dbg_wdata_d   = dbg_wdata_q;
    dbg_valid_d   = commit_s;
    retired_cnt_d = retired_cnt_q;
    if (commit_s) begin
      dbg_pc_d      = wb_pc4_i - 32'd4;
      dbg_we_d      = {4{wr_en_s}};
      dbg_wnum_d    = wb_wr_i;
      dbg_wdata_d   = wb_wd_i;
      retired_cnt_d = retired_cnt_q + 32'd1;
    end else begin
      retired_cnt_d = retired_cnt_q;
    end
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      dbg_pc_q      <= 32'd0;
      dbg_we_q      <= 4'd0;
      dbg_wnum_q    <= '0;
      dbg_wdata_q   <= '0;
      dbg_valid_q   <= 1'b0;
      retired_cnt_q <= 32'd0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
      dbg_pc_q      <= dbg_pc_d;
      dbg_we_q      <= dbg_we_d;
      dbg_wnum_q    <= dbg_wnum_d;
      dbg_wdata_q   <= dbg_wdata_d;
      dbg_valid_q   <= dbg_valid_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign dbg_pc_o      = dbg_pc_q;
  assign dbg_we_o      = dbg_we_q;
  assign dbg_wnum_o    = dbg_wnum_q;
  assign dbg_wdata_o   = dbg_wdata_q;
  assign dbg_valid_o   = dbg_valid_q;
  assign retired_cnt_o = retired_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (default build; WB_BYPASS_EN selects bypass expectations).
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        stop_i;
  logic        wb_we_i;
  logic [4:0]  wb_wr_i;
  logic [31:0] wb_wd_i;
  logic [31:0] wb_pc4_i;
  logic        wb_have_inst_i;
  logic [4:0]  ra1_i, ra2_i;
  logic [31:0] rd1_o, rd2_o;
  logic [31:0] dbg_pc_o;
  logic [3:0]  dbg_we_o;
  logic [4:0]  dbg_wnum_o;
  logic [31:0] dbg_wdata_o;
  logic        dbg_valid_o;
  logic [31:0] retired_cnt_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  wb_regfile #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stop_i(stop_i),
    .wb_we_i(wb_we_i), .wb_wr_i(wb_wr_i), .wb_wd_i(wb_wd_i),
    .wb_pc4_i(wb_pc4_i), .wb_have_inst_i(wb_have_inst_i),
    .ra1_i(ra1_i), .ra2_i(ra2_i), .rd1_o(rd1_o), .rd2_o(rd2_o),
    .dbg_pc_o(dbg_pc_o), .dbg_we_o(dbg_we_o), .dbg_wnum_o(dbg_wnum_o),
    .dbg_wdata_o(dbg_wdata_o), .dbg_valid_o(dbg_valid_o),
    .retired_cnt_o(retired_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wb();
    wb_we_i = 1'b0; wb_wr_i = 5'd0; wb_wd_i = 32'd0;
    wb_have_inst_i = 1'b0; wb_pc4_i = 32'd0; stop_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle_wb(); ra1_i = 5'd0; ra2_i = 5'd0;

    // 1 reset
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1_i = 5'(i); ra2_i = 5'(31 - i);
      #1;
      check("reset_rd1", rd1_o, 32'd0);
      check("reset_rd2", rd2_o, 32'd0);
    end
    check("reset_valid", {31'd0, dbg_valid_o}, 32'd0);
    check("reset_cnt", retired_cnt_o, 32'd0);
    check("reset_pc", dbg_pc_o, 32'd0);

    // 2 write/read with trace
    wb_we_i = 1'b1; wb_wr_i = 5'd5; wb_wd_i = 32'hDEAD_BEEF;
    wb_pc4_i = 32'h1C00_0004; wb_have_inst_i = 1'b1;
    tick();
    idle_wb(); ra1_i = 5'd5;
    #1;
    check("wr_rd1", rd1_o, 32'hDEAD_BEEF);
    check("wr_valid", {31'd0, dbg_valid_o}, 32'd1);
    check("wr_pc", dbg_pc_o, 32'h1C00_0000);
    check("wr_we", {28'd0, dbg_we_o}, 32'h0000_000F);
    check("wr_wnum", {27'd0, dbg_wnum_o}, 32'd5);
    check("wr_wdata", dbg_wdata_o, 32'hDEAD_BEEF);
    check("wr_cnt", retired_cnt_o, 32'd1);

    // 3 write to x0 is dropped but still traced
    wb_we_i = 1'b1; wb_wr_i = 5'd0; wb_wd_i = 32'h1234_5678;
    wb_pc4_i = 32'h1C00_0008; wb_have_inst_i = 1'b1;
    tick();
    idle_wb(); ra1_i = 5'd0;
    #1;
    check("x0_rd1", rd1_o, 32'd0);
    check("x0_valid", {31'd0, dbg_valid_o}, 32'd1);
    check("x0_we", {28'd0, dbg_we_o}, 32'd0);
    check("x0_wnum", {27'd0, dbg_wnum_o}, 32'd0);
    check("x0_pc", dbg_pc_o, 32'h1C00_0004);
    check("x0_cnt", retired_cnt_o, 32'd2);
    tick();
    check("idle_valid", {31'd0, dbg_valid_o}, 32'd0);
    check("idle_pc_hold", dbg_pc_o, 32'h1C00_0004);
    check("idle_wdata_hold", dbg_wdata_o, 32'h1234_5678);

    // 4 same-cycle read of the register being written
    wb_we_i = 1'b1; wb_wr_i = 5'd7; wb_wd_i = 32'h1111_1111;
    tick();
    wb_wd_i = 32'hA5A5_A5A5; ra2_i = 5'd7;
    #1;
`ifdef WB_BYPASS_EN
    check("byp_same_cycle", rd2_o, 32'hA5A5_A5A5);
`else
    check("byp_same_cycle", rd2_o, 32'h1111_1111);
`endif
    tick();
    idle_wb();
    #1;
    check("byp_next_cycle", rd2_o, 32'hA5A5_A5A5);
    check("byp_cnt", retired_cnt_o, 32'd2);

    // 5 stall: counted once when stop_i drops
    wb_have_inst_i = 1'b1; stop_i = 1'b1; wb_pc4_i = 32'h1C00_0100;
    wb_we_i = 1'b1; wb_wr_i = 5'd3; wb_wd_i = 32'h0000_0033;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'd0, dbg_valid_o}, 32'd0);
      check("stall_cnt", retired_cnt_o, 32'd2);
    end
    stop_i = 1'b0;
    tick();
    check("unstall_valid", {31'd0, dbg_valid_o}, 32'd1);
    check("unstall_pc", dbg_pc_o, 32'h1C00_00FC);
    check("unstall_cnt", retired_cnt_o, 32'd3);
    idle_wb(); ra1_i = 5'd3;
    tick();
    check("unstall_pulse_end", {31'd0, dbg_valid_o}, 32'd0);
    check("stall_rf3", rd1_o, 32'h0000_0033);

    // 5b discarded insts: no trace, no count, but the write still lands
    wb_have_inst_i = 1'b1; wb_pc4_i = 32'h8000_0010;
    tick();
    check("discard_valid", {31'd0, dbg_valid_o}, 32'd0);
    check("discard_cnt", retired_cnt_o, 32'd3);
    wb_pc4_i = 32'h8000_0020; wb_we_i = 1'b1; wb_wr_i = 5'd9; wb_wd_i = 32'h0000_0099;
    tick();
    idle_wb(); ra1_i = 5'd9;
    #1;
    check("discard_wr_rf9", rd1_o, 32'h0000_0099);
    check("discard_wr_valid", {31'd0, dbg_valid_o}, 32'd0);
    check("discard_wr_cnt", retired_cnt_o, 32'd3);
    check("discard_pc_hold", dbg_pc_o, 32'h1C00_00FC);

    // 6 counter wrap
    force dut.retired_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt_q;
    #1;
    check("wrap_preset", retired_cnt_o, 32'hFFFF_FFFF);
    wb_have_inst_i = 1'b1; wb_pc4_i = 32'h1C00_0200;
    tick();
    check("wrap_cnt", retired_cnt_o, 32'd0);
    check("wrap_valid", {31'd0, dbg_valid_o}, 32'd1);

    // 6b reset wins over a simultaneous write and commit
    rst = 1'b1; wb_we_i = 1'b1; wb_wr_i = 5'd10; wb_wd_i = 32'h0000_AAAA;
    wb_have_inst_i = 1'b1; wb_pc4_i = 32'h1C00_0300;
    tick();
    rst = 1'b0; idle_wb(); ra1_i = 5'd10; ra2_i = 5'd5;
    #1;
    check("rst_rf10", rd1_o, 32'd0);
    check("rst_rf5", rd2_o, 32'd0);
    check("rst_cnt", retired_cnt_o, 32'd0);
    check("rst_valid", {31'd0, dbg_valid_o}, 32'd0);
    check("rst_pc", dbg_pc_o, 32'd0);
    check("rst_we", {28'd0, dbg_we_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
